data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 58 +++++
 rtl/data_mem_responder_byte_ram.sv | 22 ++
 rtl/data_mem_responder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types for the core: instruction-decode opcodes, memory access widths
// and the data-memory responder state encoding, plus width helper functions.
package data_mem_responder_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_BRANCH = 7'b1100011,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111
  } opcode_e;

  // funct3 of loads/stores
  typedef enum logic [2:0] {
    BITS8   = 3'b000,
    BITS16  = 3'b001,
    BITS32  = 3'b010,
    BITS8U  = 3'b100,
    BITS16U = 3'b101
  } mem_width_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRANSFER = 2'd1,
    RESPOND  = 2'd2
  } mem_state_e;

  function automatic logic [2:0] width_bytes(input logic [2:0] w);
    case (w)
      BITS16, BITS16U: width_bytes = 3'd2;
      BITS32:          width_bytes = 3'd4;
      default:         width_bytes = 3'd1;
    endcase
  endfunction

  function automatic logic width_legal(input logic write, input logic [2:0] w);
    case (w)
      BITS8, BITS16, BITS32: width_legal = 1'b1;
      BITS8U, BITS16U:       width_legal = !write;
      default:               width_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] v, input logic [2:0] w);
    case (w)
      BITS8:   load_extend = {{24{v[7]}}, v[7:0]};
      BITS16:  load_extend = {{16{v[15]}}, v[15:0]};
      BITS8U:  load_extend = {24'd0, v[7:0]};
      BITS16U: load_extend = {16'd0, v[15:0]};
      default: load_extend = v;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_byte_ram.sv
// Byte-wide data memory: single port, synchronous write, combinational read.
// Contents are intentionally not reset.
module byte_ram #(
  parameter int unsigned DEPTH_BYTES = 256,
  parameter int unsigned AW = $clog2(DEPTH_BYTES)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH_BYTES];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store, moves one byte per cycle
// through byte_ram, then holds the response until the initiator takes it.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | req_ready=1, waiting for a request
// TRANSFER | one byte per cycle; a rejected request spends a single cycle
//          | here with no memory activity so its response lands one cycle later
// RESPOND  | rsp_valid=1, rdata/err held until rsp_ready
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_width,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);

  mem_state_e    state_q, state_d;
  logic          write_q;
  logic [2:0]    width_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    idx_q;
  logic          err_q;
  logic [31:0]   rdata_q;

  logic          accept;
  logic [2:0]    req_nb;
  logic [32:0]   req_last_addr;
  logic          req_err;
  logic [2:0]    cur_nb;
  logic          last_byte;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;
  logic [31:0]   assembled;

  assign accept = req_valid && req_ready;

  // request check uses the full 32-bit address so nothing wraps
  assign req_nb        = width_bytes(req_width);
  assign req_last_addr = {1'b0, req_addr} + 33'(req_nb) - 33'd1;
  assign req_err       = !width_legal(req_write, req_width)
                      || ((req_addr[1:0] & 2'(req_nb - 3'd1)) != 2'd0)
                      || (req_last_addr >= 33'(DEPTH_BYTES));

  assign cur_nb    = width_bytes(width_q);
  assign last_byte = ({1'b0, idx_q} == (cur_nb - 3'd1));

  assign ram_we    = (state_q == TRANSFER) && write_q && !err_q;
  assign ram_addr  = addr_q + AW'(idx_q);
  assign ram_wdata = wdata_q[8*idx_q +: 8];
  assign assembled = rdata_q | ({24'd0, ram_rdata} << {idx_q, 3'b000});

  byte_ram #(.DEPTH_BYTES(DEPTH_BYTES)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept) state_d = TRANSFER;
      TRANSFER: if (err_q || last_byte) state_d = RESPOND;
      RESPOND:  if (rsp_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESPOND);
    rsp_rdata = (state_q == RESPOND) ? rdata_q : 32'd0;
    rsp_err   = (state_q == RESPOND) && err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q <= 1'b0;
      width_q <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      idx_q   <= 2'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            write_q <= req_write;
            width_q <= req_width;
            addr_q  <= req_addr[AW-1:0];
            wdata_q <= req_wdata;
            err_q   <= req_err;
            idx_q   <= 2'd0;
            rdata_q <= 32'd0;
          end
        end
        TRANSFER: begin
          if (!err_q) begin
            idx_q <= idx_q + 2'd1;
            if (!write_q) rdata_q <= last_byte ? load_extend(assembled, width_q) : assembled;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
